acc_exec_ctrl: RTL and testbench

- Execute/writeback controller wrapped around the ALU.
- Accepts one decoded instruction per handshake and holds the architectural state: accumulator acc, registers x0..x6, PC and the flag register.
- Drives the ALU operands and one-hot mode, captures the ALU result and flags, commits to the destination, then advances or branches the PC.
- Sits between the decoder (upstream) and the ALU (combinational, consumed in the EXEC cycle).

---
 rtl/acc_exec_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_acc_exec_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_exec_ctrl.sv
// acc_exec_ctrl: execute/writeback controller wrapped around an external
// combinational ALU. Accepts one decoded instruction per handshake and
// sequences it through IDLE -> EXEC -> WB. There is no pipelining.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   insn_valid/insn_ready decoder handshake; ready is high only in IDLE
//   insn_op/rs/imm        decoded opcode, register select, 4-bit immediate
//   alu_a/alu_b/alu_mode  ALU operands and one-hot mode (driven in EXEC only)
//   alu_c/alu_flags       ALU result and {GT, EQ} flags
//   acc, pc, flags_q      architectural accumulator, program counter, flags
//   commit                one-cycle pulse in WB
//   illegal               one-cycle pulse in WB for opcodes D..F

`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 7
`endif
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`endif

module acc_exec_ctrl #(
    parameter int BIT_COUNT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       insn_valid,
    output logic                       insn_ready,
    input  logic [3:0]                 insn_op,
    input  logic [2:0]                 insn_rs,
    input  logic [3:0]                 insn_imm,
    output logic [BIT_COUNT-1:0]       alu_a,
    output logic [BIT_COUNT-1:0]       alu_b,
    output logic [`ALU_MODE_COUNT-1:0] alu_mode,
    input  logic [BIT_COUNT-1:0]       alu_c,
    input  logic [`ALU_FLAG_COUNT-1:0] alu_flags,
    output logic [BIT_COUNT-1:0]       acc,
    output logic [BIT_COUNT-1:0]       pc,
    output logic [`ALU_FLAG_COUNT-1:0] flags_q,
    output logic                       commit,
    output logic                       illegal
);

    // One-hot mode bit positions and flag bit positions.
    localparam int M_ADD   = 0;
    localparam int M_SHIFT = 1;
    localparam int M_NOT   = 2;
    localparam int M_AND   = 3;
    localparam int M_OR    = 4;
    localparam int M_XOR   = 5;
    localparam int M_BYP   = 6;
    localparam int F_EQ    = 0;
    localparam int F_GT    = 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SH   = 4'h2;
    localparam logic [3:0] OP_SHI  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_MVA  = 4'h8;
    localparam logic [3:0] OP_MVX  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BGT  = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]                 op_q;
    logic [2:0]                 rs_q;
    logic [3:0]                 imm_q;
    logic [BIT_COUNT-1:0]       acc_q;
    logic [BIT_COUNT-1:0]       pc_q;
    logic [BIT_COUNT-1:0]       result_q;
    logic [`ALU_FLAG_COUNT-1:0] flg_q;
    logic [BIT_COUNT-1:0]       xr [0:6];

    logic [BIT_COUNT-1:0]       xsel;
    logic [BIT_COUNT-1:0]       imm_z;
    logic [BIT_COUNT-1:0]       imm_s;
    logic [`ALU_MODE_COUNT-1:0] mode_dec;
    logic                       b_from_x;
    logic                       b_from_imm;
    logic                       wr_acc;
    logic                       wr_x;
    logic                       cap_flags;
    logic                       is_illegal;
    logic                       taken;

    // rs=7 is reserved and reads as zero.
    assign xsel  = (rs_q == 3'd7) ? '0 : xr[rs_q];
    assign imm_z = {{(BIT_COUNT-4){1'b0}}, imm_q};
    assign imm_s = {{(BIT_COUNT-4){imm_q[3]}}, imm_q};

    always_comb begin
        mode_dec   = '0;
        b_from_x   = 1'b0;
        b_from_imm = 1'b0;
        wr_acc     = 1'b0;
        wr_x       = 1'b0;
        cap_flags  = 1'b0;
        is_illegal = 1'b0;
        case (op_q)
            OP_ADD:  begin mode_dec[M_ADD]   = 1'b1; b_from_x   = 1'b1; wr_acc = 1'b1; end
            OP_ADDI: begin mode_dec[M_ADD]   = 1'b1; b_from_imm = 1'b1; wr_acc = 1'b1; end
            OP_SH:   begin mode_dec[M_SHIFT] = 1'b1; b_from_x   = 1'b1; wr_acc = 1'b1; end
            OP_SHI:  begin mode_dec[M_SHIFT] = 1'b1; b_from_imm = 1'b1; wr_acc = 1'b1; end
            OP_NOT:  begin mode_dec[M_NOT]   = 1'b1; wr_acc = 1'b1; end
            OP_AND:  begin mode_dec[M_AND]   = 1'b1; b_from_x = 1'b1; wr_acc = 1'b1; end
            OP_OR:   begin mode_dec[M_OR]    = 1'b1; b_from_x = 1'b1; wr_acc = 1'b1; end
            OP_XOR:  begin
                mode_dec[M_XOR] = 1'b1; b_from_x = 1'b1; wr_acc = 1'b1; cap_flags = 1'b1;
            end
            OP_MVA:  begin mode_dec[M_BYP] = 1'b1; wr_x = 1'b1; end
            OP_MVX:  wr_acc = 1'b1;
            OP_LDI:  wr_acc = 1'b1;
            OP_BEQ, OP_BGT: begin
                mode_dec[M_XOR] = 1'b1; b_from_x = 1'b1; cap_flags = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

    // In WB flags_q already holds the flags captured in this instruction's EXEC.
    assign taken = ((op_q == OP_BEQ) && flg_q[F_EQ]) ||
                   ((op_q == OP_BGT) && flg_q[F_GT]);

    // ALU interface is quiet outside EXEC so mode is zero or one-hot.
    always_comb begin
        alu_mode = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (state == S_EXEC) begin
            alu_mode = mode_dec;
            alu_a    = acc_q;
            if (b_from_x)
                alu_b = xsel;
            else if (b_from_imm)
                alu_b = imm_z;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (insn_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            rs_q     <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
            pc_q     <= '0;
            result_q <= '0;
            flg_q    <= '0;
            for (int i = 0; i < 7; i++)
                xr[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (insn_valid) begin
                        op_q  <= insn_op;
                        rs_q  <= insn_rs;
                        imm_q <= insn_imm;
                    end
                end
                S_EXEC: begin
                    // MVX and LDI bypass the ALU entirely.
                    if (op_q == OP_MVX)
                        result_q <= xsel;
                    else if (op_q == OP_LDI)
                        result_q <= imm_z;
                    else
                        result_q <= alu_c;
                    if (cap_flags)
                        flg_q <= alu_flags;
                end
                S_WB: begin
                    if (wr_acc)
                        acc_q <= result_q;
                    if (wr_x && (rs_q != 3'd7))
                        xr[rs_q] <= result_q;
                    pc_q <= taken ? pc_q + imm_s : pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign insn_ready = (state == S_IDLE);
    assign commit     = (state == S_WB);
    assign illegal    = (state == S_WB) && is_illegal;
    assign acc        = acc_q;
    assign pc         = pc_q;
    assign flags_q    = flg_q;

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Self-checking bench for acc_exec_ctrl: a directed vector table, randomized
// instructions against an instruction-level reference model, and a
// mid-instruction reset sequence. The ALU is modelled here combinationally.

`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 7
`endif
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`endif

module tb_acc_exec_ctrl;

    localparam logic [6:0] MD_NONE = 7'h00;
    localparam logic [6:0] MD_ADD  = 7'h01;
    localparam logic [6:0] MD_SH   = 7'h02;
    localparam logic [6:0] MD_NOT  = 7'h04;
    localparam logic [6:0] MD_AND  = 7'h08;
    localparam logic [6:0] MD_OR   = 7'h10;
    localparam logic [6:0] MD_XOR  = 7'h20;
    localparam logic [6:0] MD_BYP  = 7'h40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       insn_valid = 1'b0;
    logic       insn_ready;
    logic [3:0] insn_op = '0;
    logic [2:0] insn_rs = '0;
    logic [3:0] insn_imm = '0;
    logic [7:0] alu_a, alu_b, alu_c;
    logic [6:0] alu_mode;
    logic [1:0] alu_flags;
    logic [7:0] acc, pc;
    logic [1:0] flags_q;
    logic       commit, illegal;

    always #5 clk = ~clk;

    acc_exec_ctrl #(.BIT_COUNT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_op(insn_op), .insn_rs(insn_rs), .insn_imm(insn_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .acc(acc), .pc(pc), .flags_q(flags_q),
        .commit(commit), .illegal(illegal)
    );

    // Bench ALU: shift is a << b[2:0]; flags are {a > b, a == b}.
    always_comb begin
        alu_c = '0;
        if (alu_mode == MD_ADD)      alu_c = alu_a + alu_b;
        else if (alu_mode == MD_SH)  alu_c = alu_a << alu_b[2:0];
        else if (alu_mode == MD_NOT) alu_c = ~alu_a;
        else if (alu_mode == MD_AND) alu_c = alu_a & alu_b;
        else if (alu_mode == MD_OR)  alu_c = alu_a | alu_b;
        else if (alu_mode == MD_XOR) alu_c = alu_a ^ alu_b;
        else if (alu_mode == MD_BYP) alu_c = alu_a;
        alu_flags = {alu_a > alu_b, alu_a == alu_b};
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Observations collected while an instruction runs.
    logic [6:0] e_mode;
    logic       e_rdy, e_commit, w_rdy, w_commit, w_ill, i_rdy;

    task automatic issue(input logic [3:0] op, input logic [2:0] rs, input logic [3:0] imm);
        int w;
        @(negedge clk);
        w = 0;
        while (!insn_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!insn_ready) chk("ready_timeout", 32'(insn_ready), 32'd1);
        insn_valid = 1'b1;
        insn_op = op;
        insn_rs = rs;
        insn_imm = imm;
        @(posedge clk);
        #1;
        // Garbage held valid outside IDLE must be ignored and not relatched.
        insn_op = 4'($urandom);
        insn_rs = 3'($urandom);
        insn_imm = 4'($urandom);
        @(negedge clk);
        e_mode = alu_mode; e_rdy = insn_ready; e_commit = commit;
        @(negedge clk);
        w_rdy = insn_ready; w_commit = commit; w_ill = illegal;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        @(negedge clk);
        i_rdy = insn_ready;
    endtask

    // Instruction-level reference model.
    logic [7:0] m_acc, m_pc;
    logic [1:0] m_fl;
    logic [7:0] m_x [0:7];
    logic       m_ill;
    logic [6:0] m_mode;

    task automatic model_reset();
        m_acc = '0; m_pc = '0; m_fl = '0; m_ill = 1'b0; m_mode = MD_NONE;
        for (int i = 0; i < 8; i++) m_x[i] = '0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [2:0] rs, input logic [3:0] imm);
        logic [7:0] b, iz, is;
        logic       tk;
        b = (rs == 3'd7) ? 8'h00 : m_x[rs];
        iz = {4'h0, imm};
        is = {{4{imm[3]}}, imm};
        tk = 1'b0;
        m_ill = 1'b0;
        m_mode = MD_NONE;
        case (op)
            4'h0: begin m_mode = MD_ADD; m_acc = m_acc + b; end
            4'h1: begin m_mode = MD_ADD; m_acc = m_acc + iz; end
            4'h2: begin m_mode = MD_SH;  m_acc = m_acc << (b % 8); end
            4'h3: begin m_mode = MD_SH;  m_acc = m_acc << (iz % 8); end
            4'h4: begin m_mode = MD_NOT; m_acc = ~m_acc; end
            4'h5: begin m_mode = MD_AND; m_acc = m_acc & b; end
            4'h6: begin m_mode = MD_OR;  m_acc = m_acc | b; end
            4'h7: begin m_mode = MD_XOR; m_fl = {m_acc > b, m_acc == b}; m_acc = m_acc ^ b; end
            4'h8: begin m_mode = MD_BYP; if (rs != 3'd7) m_x[rs] = m_acc; end
            4'h9: m_acc = b;
            4'hA: m_acc = iz;
            4'hB: begin m_mode = MD_XOR; m_fl = {m_acc > b, m_acc == b}; tk = (m_acc == b); end
            4'hC: begin m_mode = MD_XOR; m_fl = {m_acc > b, m_acc == b}; tk = (m_acc > b); end
            default: m_ill = 1'b1;
        endcase
        m_pc = tk ? m_pc + is : m_pc + 8'd1;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [2:0] rs;
        logic [3:0] imm;
        logic [7:0] acc;
        logic [7:0] pc;
        logic [1:0] fl;
        logic       ill;
        logic [6:0] mode;
    } vec_t;

    vec_t vt [23];

    task automatic do_reset();
        insn_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{4'hA, 3'd0, 4'h5, 8'h05, 8'h01, 2'b00, 1'b0, MD_NONE};
        vt[1]  = '{4'h1, 3'd0, 4'h3, 8'h08, 8'h02, 2'b00, 1'b0, MD_ADD};
        vt[2]  = '{4'hA, 3'd0, 4'hF, 8'h0F, 8'h03, 2'b00, 1'b0, MD_NONE};
        vt[3]  = '{4'h8, 3'd2, 4'h0, 8'h0F, 8'h04, 2'b00, 1'b0, MD_BYP};
        vt[4]  = '{4'hA, 3'd0, 4'h0, 8'h00, 8'h05, 2'b00, 1'b0, MD_NONE};
        vt[5]  = '{4'h9, 3'd2, 4'h0, 8'h0F, 8'h06, 2'b00, 1'b0, MD_NONE};
        vt[6]  = '{4'hB, 3'd2, 4'hC, 8'h0F, 8'h02, 2'b01, 1'b0, MD_XOR};
        vt[7]  = '{4'hE, 3'd0, 4'h0, 8'h0F, 8'h03, 2'b01, 1'b1, MD_NONE};
        vt[8]  = '{4'h8, 3'd7, 4'h0, 8'h0F, 8'h04, 2'b01, 1'b0, MD_BYP};
        vt[9]  = '{4'h9, 3'd7, 4'h0, 8'h00, 8'h05, 2'b01, 1'b0, MD_NONE};
        vt[10] = '{4'hA, 3'd0, 4'h1, 8'h01, 8'h06, 2'b01, 1'b0, MD_NONE};
        vt[11] = '{4'hC, 3'd2, 4'h2, 8'h01, 8'h07, 2'b00, 1'b0, MD_XOR};
        vt[12] = '{4'h7, 3'd2, 4'h0, 8'h0E, 8'h08, 2'b00, 1'b0, MD_XOR};
        vt[13] = '{4'hA, 3'd0, 4'hF, 8'h0F, 8'h09, 2'b00, 1'b0, MD_NONE};
        vt[14] = '{4'hB, 3'd2, 4'hC, 8'h0F, 8'h05, 2'b01, 1'b0, MD_XOR};
        vt[15] = '{4'hB, 3'd2, 4'hC, 8'h0F, 8'h01, 2'b01, 1'b0, MD_XOR};
        vt[16] = '{4'hB, 3'd2, 4'hE, 8'h0F, 8'hFF, 2'b01, 1'b0, MD_XOR};
        vt[17] = '{4'h1, 3'd0, 4'h0, 8'h0F, 8'h00, 2'b01, 1'b0, MD_ADD};
        vt[18] = '{4'h1, 3'd0, 4'h1, 8'h10, 8'h01, 2'b01, 1'b0, MD_ADD};
        vt[19] = '{4'h1, 3'd0, 4'h0, 8'h10, 8'h02, 2'b01, 1'b0, MD_ADD};
        vt[20] = '{4'hC, 3'd2, 4'hC, 8'h10, 8'hFE, 2'b10, 1'b0, MD_XOR};
        vt[21] = '{4'hB, 3'd2, 4'hE, 8'h10, 8'hFF, 2'b10, 1'b0, MD_XOR};
        vt[22] = '{4'hD, 3'd0, 4'h0, 8'h10, 8'h00, 2'b10, 1'b1, MD_NONE};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_flags", 32'(flags_q), 32'h0);
        chk("rst_commit", 32'(commit), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_mode", 32'(alu_mode), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_ready", 32'(insn_ready), 32'h1);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            issue(vt[i].op, vt[i].rs, vt[i].imm);
            chk($sformatf("v%0d_mode", i), 32'(e_mode), 32'(vt[i].mode));
            chk($sformatf("v%0d_exec_ready", i), 32'(e_rdy), 32'h0);
            chk($sformatf("v%0d_exec_commit", i), 32'(e_commit), 32'h0);
            chk($sformatf("v%0d_wb_ready", i), 32'(w_rdy), 32'h0);
            chk($sformatf("v%0d_wb_commit", i), 32'(w_commit), 32'h1);
            chk($sformatf("v%0d_illegal", i), 32'(w_ill), 32'(vt[i].ill));
            chk($sformatf("v%0d_acc", i), 32'(acc), 32'(vt[i].acc));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].pc));
            chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vt[i].fl));
            chk($sformatf("v%0d_idle_ready", i), 32'(i_rdy), 32'h1);
        end

        // Randomized instructions against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            logic [2:0] rs;
            logic [3:0] imm;
            op = 4'($urandom);
            rs = 3'($urandom);
            imm = 4'($urandom);
            model_step(op, rs, imm);
            issue(op, rs, imm);
            chk($sformatf("r%0d_mode", i), 32'(e_mode), 32'(m_mode));
            chk($sformatf("r%0d_onehot", i), 32'($onehot0(e_mode)), 32'h1);
            chk($sformatf("r%0d_commit", i), 32'(w_commit), 32'h1);
            chk($sformatf("r%0d_illegal", i), 32'(w_ill), 32'(m_ill));
            chk($sformatf("r%0d_acc", i), 32'(acc), 32'(m_acc));
            chk($sformatf("r%0d_pc", i), 32'(pc), 32'(m_pc));
            chk($sformatf("r%0d_flags", i), 32'(flags_q), 32'(m_fl));
        end

        // Reset asserted during EXEC of an ADD abandons it.
        do_reset();
        issue(4'hA, 3'd0, 4'h7);
        issue(4'h8, 3'd1, 4'h0);
        @(negedge clk);
        insn_valid = 1'b1; insn_op = 4'h1; insn_rs = 3'd0; insn_imm = 4'h3;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_mode", 32'(alu_mode), 32'(MD_ADD));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", 32'(acc), 32'h0);
        chk("mid_rst_pc", 32'(pc), 32'h0);
        chk("mid_rst_mode", 32'(alu_mode), 32'h0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'h0);
        chk("mid_rst_commit", 32'(commit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(insn_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_rst_no_wb_acc", 32'(acc), 32'h0);
        chk("mid_rst_no_commit", 32'(commit), 32'h0);
        // x1 was cleared by reset as well.
        issue(4'h9, 3'd1, 4'h0);
        chk("post_rst_x1", 32'(acc), 32'h0);
        chk("post_rst_pc", 32'(pc), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
